// File: rtl/vga_console_pkg.sv
// Shared definitions for the character-stream console: FSM states, control codes,
// video window layout and the cell address helper.
package vga_console_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_CHAR,
    ST_WR_ATTR,
    ST_CLEAR_CHAR,
    ST_CLEAR_ATTR
  } state_e;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  localparam logic [15:0] WIN_BASE    = 16'h6000;
  localparam logic [15:0] ATTR_OFFSET = 16'h1000;
  localparam logic [7:0]  BLANK_GLYPH = 8'h20;

  // Rows are laid out on a fixed 64-cell pitch regardless of the visible width.
  function automatic logic [15:0] cell_addr(input logic [5:0] row, input logic [5:0] col,
                                            input logic is_attr);
    return WIN_BASE | (is_attr ? ATTR_OFFSET : 16'h0000) | {4'b0000, row, col};
  endfunction

endpackage

// File: rtl/vga_console_cursor.sv
// Column/row cursor with advance, CR, LF, BS and zero controls; wraps at COLS/ROWS.
// Also serves as the cell scan counter during a screen clear.
module vga_console_cursor #(
  parameter int COLS = 50,
  parameter int ROWS = 37
) (
  input  logic       clk_i,
  input  logic       n_reset_i,
  input  logic       inc_i,
  input  logic       cr_i,
  input  logic       lf_i,
  input  logic       bs_i,
  input  logic       zero_i,
  output logic [5:0] col_o,
  output logic [5:0] row_o,
  output logic [5:0] next_col_o,
  output logic [5:0] next_row_o
);

  logic [5:0] col_q, col_d;
  logic [5:0] row_q, row_d;
  logic [5:0] row_wrap;

  assign row_wrap = (row_q == 6'(ROWS - 1)) ? 6'd0 : row_q + 6'd1;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (zero_i) begin
      col_d = 6'd0;
      row_d = 6'd0;
    end else if (inc_i) begin
      if (col_q == 6'(COLS - 1)) begin
        col_d = 6'd0;
        row_d = row_wrap;
      end else begin
        col_d = col_q + 6'd1;
      end
    end else if (cr_i) begin
      col_d = 6'd0;
    end else if (lf_i) begin
      row_d = row_wrap;
    end else if (bs_i && (col_q != 6'd0)) begin
      col_d = col_q - 6'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!n_reset_i) begin
      col_q <= 6'd0;
      row_q <= 6'd0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o      = col_q;
  assign row_o      = row_q;
  assign next_col_o = col_d;
  assign next_row_o = row_d;

endmodule

// File: rtl/vga_console.sv
// Byte-stream console driving character/colour writes into the 0x6000-0x7FFF window.
// Optional screen clear on form feed when VGA_CONSOLE_CLEAR_EN is defined.
module vga_console
  import vga_console_pkg::*;
#(
  parameter int COLS = 50,
  parameter int ROWS = 37
) (
  input  logic        sys_clk,
  input  logic        n_reset,
  input  logic [7:0]  in_data,
  input  logic [7:0]  in_attr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] vid_addr,
  output logic [7:0]  vid_data,
  output logic        vid_we,
  output logic [5:0]  cursor_col,
  output logic [5:0]  cursor_row,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [7:0]  attr_q, attr_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        inc, cr, lf, bs, zero;
  logic [5:0]  col, row, next_col, next_row;

  vga_console_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk_i      (sys_clk),
    .n_reset_i  (n_reset),
    .inc_i      (inc),
    .cr_i       (cr),
    .lf_i       (lf),
    .bs_i       (bs),
    .zero_i     (zero),
    .col_o      (col),
    .row_o      (row),
    .next_col_o (next_col),
    .next_row_o (next_row)
  );

  // Character writes address the cursor's next position: it equals the current one on
  // a printable accept, and is the freshly advanced/zeroed cell during a clear.
  always_comb begin
    state_d = state_q;
    attr_d  = attr_q;
    we_d    = 1'b0;
    addr_d  = 16'h0000;
    data_d  = 8'h00;
    inc     = 1'b0;
    cr      = 1'b0;
    lf      = 1'b0;
    bs      = 1'b0;
    zero    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          attr_d = in_attr;
          case (in_data)
            CH_CR: cr = 1'b1;
            CH_LF: lf = 1'b1;
            CH_BS: bs = 1'b1;
`ifdef VGA_CONSOLE_CLEAR_EN
            CH_FF: begin
              zero    = 1'b1;
              state_d = ST_CLEAR_CHAR;
              we_d    = 1'b1;
              addr_d  = cell_addr(next_row, next_col, 1'b0);
              data_d  = BLANK_GLYPH;
            end
`else
            CH_FF: ;
`endif
            default: begin
              state_d = ST_WR_CHAR;
              we_d    = 1'b1;
              addr_d  = cell_addr(next_row, next_col, 1'b0);
              data_d  = in_data;
            end
          endcase
        end
      end
      ST_WR_CHAR: begin
        state_d = ST_WR_ATTR;
        we_d    = 1'b1;
        addr_d  = cell_addr(row, col, 1'b1);
        data_d  = attr_q;
      end
      ST_WR_ATTR: begin
        inc     = 1'b1;
        state_d = ST_IDLE;
      end
`ifdef VGA_CONSOLE_CLEAR_EN
      ST_CLEAR_CHAR: begin
        state_d = ST_CLEAR_ATTR;
        we_d    = 1'b1;
        addr_d  = cell_addr(row, col, 1'b1);
        data_d  = attr_q;
      end
      ST_CLEAR_ATTR: begin
        inc = 1'b1;
        if (col == 6'(COLS - 1) && row == 6'(ROWS - 1)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CLEAR_CHAR;
          we_d    = 1'b1;
          addr_d  = cell_addr(next_row, next_col, 1'b0);
          data_d  = BLANK_GLYPH;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!n_reset) begin
      state_q <= ST_IDLE;
      attr_q  <= 8'h00;
      we_q    <= 1'b0;
      addr_q  <= 16'h0000;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      attr_q  <= attr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign vid_we     = we_q;
  assign vid_addr   = addr_q;
  assign vid_data   = data_q;
  assign cursor_col = col;
  assign cursor_row = row;

endmodule

// File: tb/tb_vga_console.sv
// Self-checking bench for vga_console: table-driven cursor vectors, cycle-exact
// sequences for the write timing and reset corner cases, and a VRAM scoreboard.
`timescale 1ns/1ps
module tb_vga_console;

  logic        sys_clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic [7:0]  in_attr = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] vid_addr;
  logic [7:0]  vid_data;
  logic        vid_we;
  logic [5:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic        busy;

  vga_console dut (
    .sys_clk    (sys_clk),
    .n_reset    (n_reset),
    .in_data    (in_data),
    .in_attr    (in_attr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .vid_addr   (vid_addr),
    .vid_data   (vid_data),
    .vid_we     (vid_we),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;
  int wr_count = 0;
  int bad_window = 0;
  int bad_idle = 0;
  logic mon_en = 1'b0;
  logic [7:0]  vram     [0:8191];
  logic [7:0]  exp_vram [0:8191];
  logic [15:0] log_addr [$];
  logic [7:0]  log_data [$];
  int mcol = 0;
  int mrow = 0;

  always @(negedge sys_clk) begin
    if (mon_en) begin
      if (vid_we) begin
        wr_count <= wr_count + 1;
        log_addr.push_back(vid_addr);
        log_data.push_back(vid_data);
        if (vid_addr[15:13] != 3'b011) bad_window <= bad_window + 1;
        else vram[vid_addr[12:0]] <= vid_data;
      end else if (vid_addr !== 16'h0000 || vid_data !== 8'h00) begin
        bad_idle <= bad_idle + 1;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] a);
    int n = 0;
    in_data = d;
    in_attr = a;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 required 1");
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (!in_ready && n < limit) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: got busy after %0d cycles required idle", limit);
    end
  endtask

  task automatic model_print(input int c, input int r, input logic [7:0] d, input logic [7:0] a);
    exp_vram[r * 64 + c] = d;
    exp_vram[4096 + r * 64 + c] = a;
  endtask

  task automatic model_advance();
    if (mcol == 49) begin
      mcol = 0;
      mrow = (mrow == 36) ? 0 : mrow + 1;
    end else begin
      mcol = mcol + 1;
    end
  endtask

  task automatic print_char(input logic [7:0] d, input logic [7:0] a);
    send(d, a);
    wait_idle(10);
    model_print(mcol, mrow, d, a);
    model_advance();
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    in_valid = 1'b0;
    repeat (3) tick();
    n_reset = 1'b1;
    tick();
    mcol = 0;
    mrow = 0;
  endtask

  typedef struct {
    logic [7:0] d;
    logic [7:0] a;
    int col;
    int row;
    int nwr;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int n0, w0, errs, pc, pr, k;
    logic [7:0] rd;

    vecs[0]  = '{8'h42, 8'h1F, 2, 0, 2};
    vecs[1]  = '{8'h0D, 8'h00, 0, 0, 0};
    vecs[2]  = '{8'h0A, 8'h00, 0, 1, 0};
    vecs[3]  = '{8'h08, 8'h00, 0, 1, 0};
    vecs[4]  = '{8'h05, 8'h3C, 1, 1, 2};
    vecs[5]  = '{8'h08, 8'h00, 0, 1, 0};
    vecs[6]  = '{8'hFF, 8'h44, 1, 1, 2};
    vecs[7]  = '{8'h20, 8'h55, 2, 1, 2};
    vecs[8]  = '{8'h0A, 8'h00, 2, 2, 0};
    vecs[9]  = '{8'h0D, 8'h00, 0, 2, 0};
    vecs[10] = '{8'h0A, 8'h00, 0, 3, 0};

    for (int i = 0; i < 8192; i++) begin
      vram[i] = 8'h00;
      exp_vram[i] = 8'h00;
    end

    // Reset values
    do_reset();
    mon_en = 1'b1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_vid_we", vid_we, 0);
    chk("reset_vid_addr", vid_addr, 0);
    chk("reset_vid_data", vid_data, 0);
    chk("reset_cursor", {cursor_row, cursor_col}, 0);

    // 'A' with cycle-exact write timing
    in_data = 8'h41; in_attr = 8'h72; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("A_char_we", vid_we, 1);
    chk("A_char_addr", vid_addr, 16'h6000);
    chk("A_char_data", vid_data, 8'h41);
    chk("A_busy_ready", {busy, in_ready}, 2'b10);
    tick();
    chk("A_attr_we", vid_we, 1);
    chk("A_attr_addr", vid_addr, 16'h7000);
    chk("A_attr_data", vid_data, 8'h72);
    tick();
    chk("A_ready_N3", in_ready, 1);
    chk("A_we_off", vid_we, 0);
    chk("A_cursor", {cursor_row, cursor_col}, {6'd0, 6'd1});
    $display("[TB] A: cursor col=%0d row=%0d", cursor_col, cursor_row);
    model_print(0, 0, 8'h41, 8'h72);
    mcol = 1;

    // Table-driven cursor vectors
    for (int i = 0; i < 11; i++) begin
      pc = mcol; pr = mrow;
      w0 = wr_count;
      send(vecs[i].d, vecs[i].a);
      wait_idle(10);
      tick();
      $display("[TB] vec %0d data=%02h col=%0d row=%0d writes=%0d", i, vecs[i].d,
               cursor_col, cursor_row, wr_count - w0);
      chk($sformatf("vec%0d_cursor", i), {cursor_row, cursor_col},
          {6'(vecs[i].row), 6'(vecs[i].col)});
      chk($sformatf("vec%0d_writes", i), wr_count - w0, vecs[i].nwr);
      if (vecs[i].nwr == 2) model_print(pc, pr, vecs[i].d, vecs[i].a);
      mcol = vecs[i].col; mrow = vecs[i].row;
    end

    // Move to (5,2) then CR, LF, BS back-to-back
    send(8'h0D, 8'h00); wait_idle(10);
    send(8'h0D, 8'h00); wait_idle(10);
    mcol = 0;
    // LF from row 3 would go to row 4; go back to row 2 by printing from known row
    // Reposition: reset-free path uses the wrap below, so just print on row 3 instead.
    for (int i = 0; i < 5; i++) print_char(8'h61 + 8'(i), 8'h17);
    chk("pre_ctl_cursor", {cursor_row, cursor_col}, {6'(mrow), 6'd5});
    w0 = wr_count;
    in_data = 8'h0D; in_valid = 1'b1;
    tick();
    chk("ctl_cr_ready", in_ready, 1);
    chk("ctl_cr_cursor", {cursor_row, cursor_col}, {6'(mrow), 6'd0});
    in_data = 8'h0A;
    tick();
    chk("ctl_lf_ready", in_ready, 1);
    chk("ctl_lf_cursor", {cursor_row, cursor_col}, {6'(mrow + 1), 6'd0});
    in_data = 8'h08;
    tick();
    in_valid = 1'b0;
    chk("ctl_bs_cursor", {cursor_row, cursor_col}, {6'(mrow + 1), 6'd0});
    tick();
    chk("ctl_no_writes", wr_count - w0, 0);
    $display("[TB] ctl: cursor col=%0d row=%0d", cursor_col, cursor_row);

    // Wrap from the last cell
    do_reset();
    for (int i = 0; i < 49; i++) print_char(8'h61 + 8'(i % 26), 8'(i));
    for (int i = 0; i < 36; i++) begin
      send(8'h0A, 8'h00); wait_idle(10);
      mrow++;
    end
    tick();
    chk("wrap_pre_cursor", {cursor_row, cursor_col}, {6'd36, 6'd49});
    n0 = log_addr.size();
    print_char(8'h5A, 8'h34);
    tick();
    chk("wrap_char_addr", log_addr[n0], 16'h6931);
    chk("wrap_char_data", log_data[n0], 8'h5A);
    chk("wrap_attr_addr", log_addr[n0 + 1], 16'h7931);
    chk("wrap_attr_data", log_data[n0 + 1], 8'h34);
    chk("wrap_cursor", {cursor_row, cursor_col}, 0);
    $display("[TB] wrap: cursor col=%0d row=%0d", cursor_col, cursor_row);

    // Reset during WR_CHAR
    print_char(8'h52, 8'h21);
    w0 = wr_count;
    in_data = 8'h51; in_attr = 8'h66; in_valid = 1'b1;
    tick();
    chk("rst_wrchar_addr", {vid_we, vid_addr}, {1'b1, 16'h6001});
    n_reset = 1'b0; in_valid = 1'b0;
    tick();
    chk("rst_we", vid_we, 0);
    chk("rst_addr", vid_addr, 0);
    chk("rst_cursor", {cursor_row, cursor_col}, 0);
    n_reset = 1'b1;
    repeat (3) tick();
    chk("rst_no_attr", wr_count - w0, 1);
    chk("rst_ready", in_ready, 1);
    exp_vram[1] = 8'h51;
    mcol = 0; mrow = 0;
    $display("[TB] reset mid-write: writes=%0d", wr_count - w0);

    // Form feed
    print_char(8'h31, 8'h0E);
    print_char(8'h32, 8'h0E);
    w0 = wr_count;
    n0 = log_addr.size();
    send(8'h0C, 8'h07);
`ifdef VGA_CONSOLE_CLEAR_EN
    chk("ff_busy", busy, 1);
    wait_idle(4000);
    tick();
    chk("ff_writes", wr_count - w0, 3700);
    errs = 0;
    for (int r = 0; r < 37; r++) begin
      for (int c = 0; c < 50; c++) begin
        k = n0 + 2 * (r * 50 + c);
        if (log_addr[k] != 16'h6000 + 16'(r * 64 + c) || log_data[k] != 8'h20) errs++;
        if (log_addr[k + 1] != 16'h7000 + 16'(r * 64 + c) || log_data[k + 1] != 8'h07) errs++;
        model_print(c, r, 8'h20, 8'h07);
      end
    end
    chk("ff_sequence_errs", errs, 0);
    chk("ff_cursor", {cursor_row, cursor_col}, 0);
    chk("ff_busy_end", busy, 0);
    mcol = 0; mrow = 0;
`else
    wait_idle(10);
    tick();
    chk("ff_writes", wr_count - w0, 0);
    chk("ff_cursor", {cursor_row, cursor_col}, {6'd0, 6'd2});
`endif
    $display("[TB] ff: writes=%0d cursor col=%0d row=%0d", wr_count - w0, cursor_col, cursor_row);

    // Random printable stream with gaps
    for (int i = 0; i < 60; i++) begin
      rd = 8'($urandom_range(0, 255));
      if (rd == 8'h08 || rd == 8'h0A || rd == 8'h0C || rd == 8'h0D) rd = 8'h41;
      repeat ($urandom_range(0, 3)) tick();
      print_char(rd, 8'($urandom_range(0, 255)));
    end
    tick();
    chk("rand_cursor", {cursor_row, cursor_col}, {6'(mrow), 6'(mcol)});
    errs = 0;
    for (int i = 0; i < 8192; i++) if (vram[i] !== exp_vram[i]) errs++;
    chk("vram_scoreboard_diffs", errs, 0);
    chk("window_violations", bad_window, 0);
    chk("idle_bus_violations", bad_idle, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
